// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, 16x-oversampled mid-bit sampling with
// start-bit validation, ready/ack byte handoff, framing-error pulse, sticky overrun.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 4
) (
    input  logic       CLK,
    input  logic       RSTb,
    input  logic       RX,
    input  logic       tick16,
    input  logic       rd_ack,
    output logic [7:0] data,
    output logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HALF = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

    state_t           state;
    logic             rx_m;
    logic             rx_s;
    logic [CNT_W-1:0] scnt;
    logic [2:0]       bcnt;
    logic [7:0]       shreg;

    always_ff @(posedge CLK) begin
        if (!RSTb) begin
            state      <= IDLE;
            rx_m       <= 1'b1;
            rx_s       <= 1'b1;
            scnt       <= '0;
            bcnt       <= '0;
            shreg      <= '0;
            data       <= 8'h00;
            data_ready <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_m      <= RX;
            rx_s      <= rx_m;
            frame_err <= 1'b0;

            // An ack releases the held byte; a commit in the same cycle overrides below.
            if (rd_ack && data_ready) begin
                data_ready <= 1'b0;
                overrun    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        scnt  <= '0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (tick16) begin
                        if (scnt == HALF) begin
                            scnt <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                                bcnt  <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick16) begin
                        if (scnt == LAST) begin
                            scnt  <= '0;
                            shreg <= {rx_s, shreg[7:1]};
                            bcnt  <= bcnt + 1'b1;
                            if (bcnt == 3'd7)
                                state <= STOP;
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick16) begin
                        if (scnt == LAST) begin
                            scnt <= '0;
                            if (rx_s) begin
                                data       <= shreg;
                                data_ready <= 1'b1;
                                overrun    <= overrun | (data_ready & ~rd_ack);
                                state      <= IDLE;
                                busy       <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= BRK;
                            end
                        end else begin
                            scnt <= scnt + 1'b1;
                        end
                    end
                end
                BRK: begin
                    // A held-low line reports once, then waits for idle.
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the receive-side counterpart of the team's uart_tx.
- Deserialises an asynchronous 8N1 serial line into bytes: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high).
- Uses a 16x-oversampling tick from the shared baud generator, with mid-bit sampling and start-bit validation.
- Presents each byte to the CPU/peripheral bus with a ready/ack handshake, plus framing-error and overrun reporting.

Parameters:
- OVERSAMPLE, 16: tick16 pulses per bit period. Must be an even value ≥ 8.
- CNT_W, 4: sample counter width, equal to clog2(OVERSAMPLE).

Ports:
- CLK  in  1  system clock
- RSTb  in  1  reset, synchronous, active-low
- RX  in  1  asynchronous serial input; idle level is high
- tick16  in  1  one-CLK pulse, OVERSAMPLE per bit period
- rd_ack  in  1  one-CLK pulse; consumer has taken data
- data  out  8  last good received byte
- data_ready  out  1  high while data holds an unacknowledged byte
- frame_err  out  1  one-CLK pulse when the stop bit samples low
- overrun  out  1  sticky; a byte completed while data_ready was 1
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (RSTb=0 at a CLK edge) gives:
  - state=IDLE; counters and shift register = 0;
  - both synchroniser flops = 1;
  - data=8'h00, data_ready=0, frame_err=0, overrun=0, busy=0.
- Reset mid-frame abandons the frame; no partial byte is ever output.
- RX passes through a 2-flop synchroniser to give rx_s (2 CLK latency). All decisions use rx_s only.
- scnt (CNT_W bits) increments only on CLK edges where tick16=1.
- IDLE:
  - if rx_s==0: go to START, scnt=0.
- START:
  - on tick16 with scnt==OVERSAMPLE/2-1: if rx_s==0, go to DATA with scnt=0, bcnt=0.
  - otherwise (rx_s==1 at that point) it is a glitch: go to IDLE, no flags.
- DATA:
  - on tick16 with scnt==OVERSAMPLE-1: shreg = {rx_s, shreg[7:1]}; scnt=0; bcnt=bcnt+1.
  - when bcnt==7 at that sample, go to STOP.
  - Each sample therefore lands mid-bit.
- STOP, on tick16 with scnt==OVERSAMPLE-1:
  - rx_s==1: data<=shreg, data_ready<=1, go to IDLE. If data_ready was already 1 and rd_ack=0 in the same cycle, overrun<=1.
  - rx_s==0: frame_err=1 for exactly one CLK; data and data_ready unchanged; go to BREAK.
- BREAK:
  - wait for rx_s==1, then go to IDLE.
  - A held-low line (break condition) produces one frame_err, not repeated frames.
- rd_ack:
  - clears data_ready and overrun on the next edge.
  - rd_ack in the same cycle as a STOP commit: data_ready stays 1 (new byte), overrun unchanged (not set).
  - rd_ack while data_ready=0 has no effect.
- Timing: data_ready rises 1 CLK after the mid-stop-bit tick, i.e. ≈9.5 bit periods + 2 CLK after the start edge on RX.
- tick16 asserted every CLK is legal; behaviour is identical in tick units.
- An unused/illegal state encoding returns to IDLE on the next edge.
- The next start bit is accepted from IDLE immediately after the stop sample. No wait for the full stop bit; this tolerates ~half-bit clock mismatch.

Test Plan:
- Use tick16 every 4 CLK (bit = 64 CLK). Drive 0xA5 as 8N1 (LSB first) → data=8'hA5, data_ready=1 at ≈608+2 CLK after the start edge, frame_err never 1, overrun=0; rd_ack pulse → data_ready=0 next cycle.
- Glitch: RX low for 3 tick16 periods (12 CLK) then high → returns to IDLE, busy falls within 8 ticks, data_ready=0, no frame_err.
- Byte 0x3C with stop bit driven low, RX held low 2 more bit times then high → exactly one frame_err pulse, data_ready=0, data unchanged (8'h00), busy=0 only after RX returns high.
- Back-to-back 0x11 then 0x22, no rd_ack → data=8'h22, data_ready=1, overrun=1; single rd_ack → data_ready=0, overrun=0.
- rd_ack coincident with the 0x22 STOP commit (0x11 pending) → data=8'h22, data_ready=1, overrun=0.
- RSTb=0 for 1 CLK at bit 4 of 0xFF, then clean 0x5A → all outputs at reset values after reset, then data=8'h5A, no stale bits, no frame_err.
